// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one segDisplay between NREQ requesters.
// Generates the digit-scan strobe and resync pulse, latches requester data
// only on frame boundaries and rotates requesters round-robin after a dwell.
// Optional feature macro: SEGARB_PRIORITY_EN adds req_urgent[NREQ], which
// preempts round-robin and dwell at the next frame boundary.
module seg_display_arbiter #(
  parameter int SEGS         = 4,
  parameter int NREQ         = 3,
  parameter int SCAN_DIV     = 50000,
  parameter int DWELL_FRAMES = 500
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ*4*SEGS-1:0]               req_data,
  input  logic [NREQ*($clog2(SEGS)+1)-1:0]     req_dp_loc,
  input  logic [NREQ-1:0]                      req_dp_en,
`ifdef SEGARB_PRIORITY_EN
  input  logic [NREQ-1:0]                      req_urgent,
`endif
  output logic [NREQ-1:0]                      req_ack,
  output logic                                 seg_update_strobe,
  output logic                                 seg_reset,
  output logic [4*SEGS-1:0]                    datain,
  output logic [$clog2(SEGS):0]                decimal_place_location,
  output logic                                 show_decimal_place,
  output logic [$clog2(NREQ)-1:0]              active_src,
  output logic                                 active_valid
);

  localparam int DW = 4 * SEGS;
  localparam int LW = $clog2(SEGS) + 1;
  localparam int SW = $clog2(NREQ);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int GW = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int CW = $clog2(DWELL_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] DIGIT_LAST = GW'(SEGS - 1);
  localparam logic [CW-1:0] DWELL_END  = CW'(DWELL_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [GW-1:0]   digit_q, digit_d;
  logic            strobe_q, strobe_d;
  logic            seg_reset_q, seg_reset_d;
  logic            resync_q, resync_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   active_src_q, active_src_d;
  logic            active_valid_q, active_valid_d;
  logic [DW-1:0]   datain_q, datain_d;
  logic [LW-1:0]   dp_loc_q, dp_loc_d;
  logic            dp_en_q, dp_en_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [DW-1:0]   data_arr [NREQ];
  logic [LW-1:0]   loc_arr  [NREQ];
  logic [NREQ-1:0] urgent_v;
  logic            frame_end;
  logic [SW:0]     rr_next;
  logic [SW-1:0]   low_valid;
  logic [SW-1:0]   low_urgent;
  logic [CW-1:0]   dwell_inc;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
    assign loc_arr[g]  = req_dp_loc[g*LW +: LW];
  end

`ifdef SEGARB_PRIORITY_EN
  assign urgent_v = req_urgent & req_valid;
`else
  assign urgent_v = '0;
`endif

  function automatic logic [SW-1:0] lowest_idx(input logic [NREQ-1:0] v);
    lowest_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SW'(i);
    end
  endfunction

  // Search starts after 'from' and wraps; 'from' itself is the last candidate.
  function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] v,
                                          input logic [SW-1:0] from);
    int idx;
    rr_pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(from) + k) % NREQ;
      if (v[idx]) rr_pick = {1'b1, SW'(idx)};
    end
  endfunction

  assign frame_end  = strobe_q && (digit_q == DIGIT_LAST);
  assign rr_next    = rr_pick(req_valid, active_src_q);
  assign low_valid  = lowest_idx(req_valid);
  assign low_urgent = lowest_idx(urgent_v);
  assign dwell_inc  = dwell_q + CW'(1);

  // Prescaler, strobe/resync generation and digit tracking; the digit follows
  // every emitted strobe even if enable drops, so it stays in step with segDisplay.
  always_comb begin
    presc_d     = presc_q;
    strobe_d    = 1'b0;
    seg_reset_d = 1'b0;
    resync_d    = resync_q;
    digit_d     = digit_q;
    if (enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d     = '0;
        strobe_d    = 1'b1;
        seg_reset_d = resync_q || (digit_q == DIGIT_LAST);
        resync_d    = 1'b0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (strobe_q) begin
      if (seg_reset_q || (digit_q == DIGIT_LAST)) digit_d = '0;
      else                                        digit_d = digit_q + GW'(1);
    end
  end

  // Arbitration FSM: picks, loads and refreshes the displayed requester.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    active_src_d   = active_src_q;
    active_valid_d = active_valid_q;
    datain_d       = datain_q;
    dp_loc_d       = dp_loc_q;
    dp_en_d        = dp_en_q;
    dwell_d        = dwell_q;
    ack_d          = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          sel_d   = (|urgent_v) ? low_urgent : low_valid;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        datain_d       = data_arr[sel_q];
        dp_loc_d       = loc_arr[sel_q];
        dp_en_d        = req_dp_en[sel_q];
        ack_d[sel_q]   = 1'b1;
        active_src_d   = sel_q;
        active_valid_d = 1'b1;
        dwell_d        = '0;
        state_d        = ST_SCAN;
      end
      ST_SCAN: begin
        if (frame_end) begin
          if (|urgent_v) begin
            sel_d   = low_urgent;
            state_d = ST_LOAD;
          end else if (!req_valid[active_src_q]) begin
            if (rr_next[SW]) begin
              sel_d   = rr_next[SW-1:0];
              state_d = ST_LOAD;
            end else begin
              datain_d       = '0;
              dp_loc_d       = '0;
              dp_en_d        = 1'b0;
              active_src_d   = '0;
              active_valid_d = 1'b0;
              dwell_d        = '0;
              state_d        = ST_IDLE;
            end
          end else if (dwell_inc == DWELL_END) begin
            sel_d   = rr_next[SW-1:0];
            state_d = ST_LOAD;
          end else begin
            datain_d            = data_arr[active_src_q];
            dp_loc_d            = loc_arr[active_src_q];
            dp_en_d             = req_dp_en[active_src_q];
            ack_d[active_src_q] = 1'b1;
            dwell_d             = dwell_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset forces a resync on the next strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      digit_q        <= '0;
      strobe_q       <= 1'b0;
      seg_reset_q    <= 1'b0;
      resync_q       <= 1'b1;
      dwell_q        <= '0;
      sel_q          <= '0;
      active_src_q   <= '0;
      active_valid_q <= 1'b0;
      datain_q       <= '0;
      dp_loc_q       <= '0;
      dp_en_q        <= 1'b0;
      ack_q          <= '0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      digit_q        <= digit_d;
      strobe_q       <= strobe_d;
      seg_reset_q    <= seg_reset_d;
      resync_q       <= resync_d;
      dwell_q        <= dwell_d;
      sel_q          <= sel_d;
      active_src_q   <= active_src_d;
      active_valid_q <= active_valid_d;
      datain_q       <= datain_d;
      dp_loc_q       <= dp_loc_d;
      dp_en_q        <= dp_en_d;
      ack_q          <= ack_d;
    end
  end

  assign req_ack                = ack_q;
  assign seg_update_strobe      = strobe_q;
  assign seg_reset              = seg_reset_q;
  assign datain                 = datain_q;
  assign decimal_place_location = dp_loc_q;
  assign show_decimal_place     = dp_en_q;
  assign active_src             = active_src_q;
  assign active_valid           = active_valid_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter: directed steps followed by randomized
// traffic, compared every cycle against a frame/strobe-count based model.
module tb_seg_display_arbiter;

  localparam int SEGS         = 4;
  localparam int NREQ         = 3;
  localparam int SCAN_DIV     = 4;
  localparam int DWELL_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [47:0] req_data = '0;
  logic [8:0]  req_dp_loc = '0;
  logic [2:0]  req_dp_en = '0;
  logic [2:0]  req_urgent = '0;

  logic [2:0]  req_ack;
  logic        seg_update_strobe;
  logic        seg_reset;
  logic [15:0] datain;
  logic [2:0]  decimal_place_location;
  logic        show_decimal_place;
  logic [1:0]  active_src;
  logic        active_valid;

  int total = 0;
  int bad = 0;

  // Model state: mode 0 = nothing shown, 1 = load pending, 2 = showing.
  int          m_mode, m_pend, m_frames, m_encnt;
  logic [15:0] m_data;
  logic [2:0]  m_loc;
  logic        m_dpen;
  logic [2:0]  m_ack;
  logic [1:0]  m_src;
  logic        m_av;
  logic        m_strobe, m_segrst;

  seg_display_arbiter #(
    .SEGS(SEGS), .NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .DWELL_FRAMES(DWELL_FRAMES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_dp_loc(req_dp_loc),
    .req_dp_en(req_dp_en),
`ifdef SEGARB_PRIORITY_EN
    .req_urgent(req_urgent),
`endif
    .req_ack(req_ack),
    .seg_update_strobe(seg_update_strobe),
    .seg_reset(seg_reset),
    .datain(datain),
    .decimal_place_location(decimal_place_location),
    .show_decimal_place(show_decimal_place),
    .active_src(active_src),
    .active_valid(active_valid)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [2:0] urgentMask();
`ifdef SEGARB_PRIORITY_EN
    return req_urgent & req_valid;
`else
    return 3'b000;
`endif
  endfunction

  function automatic int lowestSet(input logic [2:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int nextAfter(input logic [2:0] v, input int from);
    for (int k = 1; k <= NREQ; k++) if (v[(from + k) % NREQ]) return (from + k) % NREQ;
    return -1;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_pend = 0; m_frames = 0; m_encnt = 0;
    m_data = '0; m_loc = '0; m_dpen = 1'b0; m_ack = '0;
    m_src = '0; m_av = 1'b0; m_strobe = 1'b0; m_segrst = 1'b0;
  endtask

  task automatic latchFrom(input int i);
    m_data = req_data[i*16 +: 16];
    m_loc  = req_dp_loc[i*3 +: 3];
    m_dpen = req_dp_en[i];
    m_ack  = 3'(1 << i);
  endtask

  task automatic modelStep();
    int n;
    int nx;
    logic fe;
    logic [2:0] u;
    if (!reset_n) begin
      modelReset();
      return;
    end
    n  = m_encnt / SCAN_DIV;
    fe = m_strobe && (n > 1) && ((n - 1) % SEGS == 0);
    u  = urgentMask();
    m_ack = '0;
    case (m_mode)
      0: begin
        if (req_valid != 3'b000) begin
          m_pend = (u != 3'b000) ? lowestSet(u) : lowestSet(req_valid);
          m_mode = 1;
        end
      end
      1: begin
        latchFrom(m_pend);
        m_src = 2'(m_pend);
        m_av = 1'b1;
        m_frames = 0;
        m_mode = 2;
      end
      default: begin
        if (fe) begin
          m_frames++;
          if (u != 3'b000) begin
            m_pend = lowestSet(u);
            m_mode = 1;
          end else if (!req_valid[m_src]) begin
            nx = nextAfter(req_valid, int'(m_src));
            if (nx < 0) begin
              m_data = '0; m_loc = '0; m_dpen = 1'b0;
              m_src = '0; m_av = 1'b0; m_mode = 0;
            end else begin
              m_pend = nx;
              m_mode = 1;
            end
          end else if (m_frames == DWELL_FRAMES) begin
            m_pend = nextAfter(req_valid, int'(m_src));
            m_mode = 1;
          end else begin
            latchFrom(int'(m_src));
          end
        end
      end
    endcase
    if (enable) begin
      m_encnt++;
      m_strobe = (m_encnt % SCAN_DIV == 0);
      n = m_encnt / SCAN_DIV;
      m_segrst = m_strobe && ((n == 1) || ((n - 1) % SEGS == 0));
    end else begin
      m_strobe = 1'b0;
      m_segrst = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("strobe", 16'(seg_update_strobe), 16'(m_strobe));
    chk("seg_reset", 16'(seg_reset), 16'(m_segrst));
    chk("datain", datain, m_data);
    chk("dp_loc", 16'(decimal_place_location), 16'(m_loc));
    chk("dp_en", 16'(show_decimal_place), 16'(m_dpen));
    chk("req_ack", 16'(req_ack), 16'(m_ack));
    chk("active_src", 16'(active_src), 16'(m_src));
    chk("active_valid", 16'(active_valid), 16'(m_av));
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input int idx, input logic [15:0] d,
                               input logic [2:0] loc, input logic dpen);
    req_valid = v;
    req_data[idx*16 +: 16] = d;
    req_dp_loc[idx*3 +: 3] = loc;
    req_dp_en[idx] = dpen;
  endtask

  // Directed steps, then randomized traffic with a mid-run reset.
  initial begin
    modelReset();
    #2 reset_n = 1'b0;
    modelReset();
    enable = 1'b1;
    #1 checkOutput();
    runCycles(3);
    reset_n = 1'b1;
    $display("[TB] idle scanning");
    runCycles(40);

    $display("[TB] single requester");
    applyStimulus(3'b001, 0, 16'h1234, 3'd1, 1'b1);
    applyStimulus(3'b001, 2, 16'hABCD, 3'd3, 1'b0);
    runCycles(20);

    $display("[TB] round robin 0 and 2");
    req_valid = 3'b101;
    applyStimulus(3'b101, 1, 16'h5555, 3'd2, 1'b1);
    runCycles(100);

    $display("[TB] mid-frame data change");
    runCycles(3);
    applyStimulus(3'b101, 0, 16'h0042, 3'd2, 1'b0);
    runCycles(40);

    $display("[TB] drop to idle");
    req_valid = 3'b001;
    runCycles(6);
    req_valid = 3'b000;
    runCycles(40);

    $display("[TB] enable pause");
    applyStimulus(3'b010, 1, 16'h9876, 3'd4, 1'b1);
    runCycles(7);
    enable = 1'b0;
    runCycles(10);
    enable = 1'b1;
    runCycles(40);

`ifdef SEGARB_PRIORITY_EN
    $display("[TB] urgent preemption");
    req_valid = 3'b101;
    runCycles(40);
    req_urgent = 3'b100;
    runCycles(40);
    req_urgent = 3'b000;
    runCycles(20);
`endif

    $display("[TB] async reset mid-frame");
    runCycles(6);
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput();
    runCycles(2);
    reset_n = 1'b1;
    runCycles(30);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 7) == 0) req_valid = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_data[31:0]  = $urandom;
        req_data[47:32] = 16'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        req_dp_loc = 9'($urandom);
        req_dp_en  = 3'($urandom);
      end
      if ($urandom_range(0, 15) == 0) req_urgent = 3'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      if (c == 450) begin
        #2 reset_n = 1'b0;
        modelReset();
        #1 checkOutput();
        runCycles(2);
        reset_n = 1'b1;
      end
      runCycles(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
